// File: rtl/nonce_dispatch_collector.sv
// nonce_dispatch_collector
//   Takes one work unit (midstate, header tail, inclusive nonce range) and
//   feeds it to NUM_CORES parallel double-SHA256 cores. One group of nonces
//   goes out every 2^LOOP_LOG2 cycles. Results come back as groups in issue
//   order, so a base nonce plus a remaining count is enough to name every
//   lane. No per-nonce storage is needed. Golden nonces (h7 == 0) are queued
//   in a first-word-fall-through FIFO for the serial TX path.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   work_*                work handshake and fields; work_abort drops the job
//   core_midstate/data    latched work shared by all cores
//   core_nonce            lane k nonce at [32k +: 32]
//   core_issue            cores sample their inputs this cycle
//   core_lane_en          lane k holds an in-range nonce
//   core_hash_valid/top   one result group, lane k h7 at [32k +: 32]
//   gold_valid/ready      FIFO pop handshake; gold_nonce is the FIFO head
//   gold_drop             saturating count of golden nonces that were lost
//   busy, done            job active; one-cycle pulse when the range retires
module nonce_dispatch_collector #(
   parameter int NUM_CORES       = 2,
   parameter int LOOP_LOG2       = 0,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    work_valid,
   output logic                    work_ready,
   input  logic [255:0]            work_midstate,
   input  logic [95:0]             work_data,
   input  logic [31:0]             work_nonce_start,
   input  logic [31:0]             work_nonce_end,
   input  logic                    work_abort,
   output logic [255:0]            core_midstate,
   output logic [95:0]             core_data,
   output logic [32*NUM_CORES-1:0] core_nonce,
   output logic                    core_issue,
   output logic [NUM_CORES-1:0]    core_lane_en,
   input  logic                    core_hash_valid,
   input  logic [32*NUM_CORES-1:0] core_hash_top,
   output logic                    gold_valid,
   input  logic                    gold_ready,
   output logic [31:0]             gold_nonce,
   output logic [7:0]              gold_drop,
   output logic                    busy,
   output logic                    done
);
   localparam int          DEPTH  = 1 << FIFO_DEPTH_LOG2;
   localparam int          CW     = FIFO_DEPTH_LOG2 + 1;
   localparam int          TW     = (LOOP_LOG2 > 0) ? LOOP_LOG2 : 1;
   localparam logic [32:0] NC33   = 33'(NUM_CORES);
   localparam logic [31:0] NC32   = 32'(NUM_CORES);
   localparam logic [TW-1:0] RELOAD = TW'((1 << LOOP_LOG2) - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                    state_reg;
   logic [31:0]               issue_nonce_reg, res_nonce_reg;
   logic [32:0]               issue_left_reg, res_left_reg;
   logic [TW-1:0]             timer_reg;
   logic [255:0]              midstate_reg;
   logic [95:0]               data_reg;
   logic [32*NUM_CORES-1:0]   nonce_reg;
   logic                      issue_reg, done_reg;
   logic [NUM_CORES-1:0]      lane_en_reg;
   logic [7:0]                drop_reg;
   logic [31:0]               fifo_mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]             count_reg;

   // The first group goes out on the acceptance edge itself, taken straight
   // from the work fields, so core_issue is high in the cycle after acceptance.
   logic        accept, issue_fire, retire;
   logic [32:0] work_n, iss_cnt, iss_take, res_take;
   logic [31:0] iss_base;

   assign accept     = (state_reg == IDLE) && work_valid && !work_abort;
   assign work_n     = {1'b0, work_nonce_end - work_nonce_start} + 33'd1;
   assign iss_base   = accept ? work_nonce_start : issue_nonce_reg;
   assign iss_cnt    = accept ? work_n : issue_left_reg;
   assign iss_take   = (iss_cnt < NC33) ? iss_cnt : NC33;
   assign issue_fire = !work_abort && (accept || (state_reg == RUN && timer_reg == '0));
   assign retire     = core_hash_valid && !work_abort &&
                       (state_reg == RUN || state_reg == DRAIN);
   assign res_take   = (res_left_reg < NC33) ? res_left_reg : NC33;

   logic [32*NUM_CORES-1:0] lane_nonce_next;
   logic [NUM_CORES-1:0]    lane_en_next, gold_vec;

   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_lane
      assign lane_nonce_next[32*gi +: 32] = iss_base + 32'(gi);
      assign lane_en_next[gi] = iss_cnt > 33'(gi);
      assign gold_vec[gi]     = retire && (res_left_reg > 33'(gi)) &&
                                (core_hash_top[32*gi +: 32] == 32'd0);
   end

   // Lowest golden lane is the one written; the rest of the group is dropped.
   logic [31:0] push_nonce;
   logic [3:0]  gold_cnt;
   always_comb begin
      push_nonce = 32'd0;
      gold_cnt   = 4'd0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         if (gold_vec[k]) begin
            push_nonce = res_nonce_reg + 32'(k);
            gold_cnt   = gold_cnt + 4'd1;
         end
      end
   end

   logic       fifo_full, pop, push_ok;
   logic [3:0] drop_inc;
   logic [8:0] drop_sum;
   assign fifo_full = (count_reg == FULL_CNT);
   assign pop       = (count_reg != '0) && gold_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok   = (gold_cnt != 4'd0) && (!fifo_full || pop);
   assign drop_inc  = gold_cnt - {3'd0, push_ok};
   assign drop_sum  = {1'b0, drop_reg} + {5'd0, drop_inc};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         issue_nonce_reg <= '0;
         res_nonce_reg   <= '0;
         issue_left_reg  <= '0;
         res_left_reg    <= '0;
         timer_reg       <= '0;
         midstate_reg    <= '0;
         data_reg        <= '0;
         nonce_reg       <= '0;
         issue_reg       <= 1'b0;
         lane_en_reg     <= '0;
         done_reg        <= 1'b0;
         drop_reg        <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
      end else begin
         done_reg  <= 1'b0;
         issue_reg <= 1'b0;
         if (work_abort) begin
            state_reg   <= IDLE;
            lane_en_reg <= '0;
         end else begin
            if (accept) begin
               midstate_reg  <= work_midstate;
               data_reg      <= work_data;
               res_nonce_reg <= work_nonce_start;
               res_left_reg  <= work_n;
            end
            if (issue_fire) begin
               issue_reg       <= 1'b1;
               nonce_reg       <= lane_nonce_next;
               lane_en_reg     <= lane_en_next;
               issue_nonce_reg <= iss_base + NC32;
               issue_left_reg  <= iss_cnt - iss_take;
               timer_reg       <= RELOAD;
               state_reg       <= (iss_cnt == iss_take) ? DRAIN : RUN;
            end else if (state_reg == RUN) begin
               timer_reg <= timer_reg - 1'b1;
            end
            if (retire) begin
               res_nonce_reg <= res_nonce_reg + NC32;
               res_left_reg  <= res_left_reg - res_take;
               if (res_left_reg == res_take) begin
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
         end

         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push_ok && !pop)      count_reg <= count_reg + 1'b1;
         else if (!push_ok && pop) count_reg <= count_reg - 1'b1;
         drop_reg <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   // Storage is left unreset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_reg] <= push_nonce;
   end

   assign work_ready    = (state_reg == IDLE);
   assign busy          = (state_reg != IDLE);
   assign done          = done_reg;
   assign core_midstate = midstate_reg;
   assign core_data     = data_reg;
   assign core_nonce    = nonce_reg;
   assign core_issue    = issue_reg;
   assign core_lane_en  = lane_en_reg;
   assign gold_valid    = (count_reg != '0);
   assign gold_nonce    = gold_valid ? fifo_mem[rd_ptr_reg] : 32'd0;
   assign gold_drop     = drop_reg;
endmodule

// File: tb/tb_nonce_dispatch_collector.sv
module tb_nonce_dispatch_collector;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, work_abort, core_hash_valid, gold_ready;
   logic [255:0]  work_midstate;
   logic [95:0]   work_data;
   logic [31:0]   ns, ne;
   logic [63:0]   hash_top;
   logic          v1, v2, v4;

   // s1: NUM_CORES=1; s2: NUM_CORES=2; s4: NUM_CORES=2, LOOP_LOG2=2
   logic         s1_ready, s1_issue, s1_en, s1_gv, s1_busy, s1_done;
   logic [255:0] s1_mid; logic [95:0] s1_data; logic [31:0] s1_nonce, s1_gn; logic [7:0] s1_drop;
   logic         s2_ready, s2_issue, s2_gv, s2_busy, s2_done;
   logic [1:0]   s2_en;
   logic [255:0] s2_mid; logic [95:0] s2_data; logic [63:0] s2_nonce; logic [31:0] s2_gn; logic [7:0] s2_drop;
   logic         s4_ready, s4_issue, s4_gv, s4_busy, s4_done;
   logic [1:0]   s4_en;
   logic [255:0] s4_mid; logic [95:0] s4_data; logic [63:0] s4_nonce; logic [31:0] s4_gn; logic [7:0] s4_drop;

   int pass_cnt = 0;
   int total_cnt = 0;

   nonce_dispatch_collector #(.NUM_CORES(1), .LOOP_LOG2(0), .FIFO_DEPTH_LOG2(2)) u1 (
      .clk(clk), .reset(reset), .work_valid(v1), .work_ready(s1_ready),
      .work_midstate(work_midstate), .work_data(work_data),
      .work_nonce_start(ns), .work_nonce_end(ne), .work_abort(work_abort),
      .core_midstate(s1_mid), .core_data(s1_data), .core_nonce(s1_nonce),
      .core_issue(s1_issue), .core_lane_en(s1_en), .core_hash_valid(core_hash_valid),
      .core_hash_top(hash_top[31:0]), .gold_valid(s1_gv), .gold_ready(gold_ready),
      .gold_nonce(s1_gn), .gold_drop(s1_drop), .busy(s1_busy), .done(s1_done));

   nonce_dispatch_collector #(.NUM_CORES(2), .LOOP_LOG2(0), .FIFO_DEPTH_LOG2(2)) u2 (
      .clk(clk), .reset(reset), .work_valid(v2), .work_ready(s2_ready),
      .work_midstate(work_midstate), .work_data(work_data),
      .work_nonce_start(ns), .work_nonce_end(ne), .work_abort(work_abort),
      .core_midstate(s2_mid), .core_data(s2_data), .core_nonce(s2_nonce),
      .core_issue(s2_issue), .core_lane_en(s2_en), .core_hash_valid(core_hash_valid),
      .core_hash_top(hash_top), .gold_valid(s2_gv), .gold_ready(gold_ready),
      .gold_nonce(s2_gn), .gold_drop(s2_drop), .busy(s2_busy), .done(s2_done));

   nonce_dispatch_collector #(.NUM_CORES(2), .LOOP_LOG2(2), .FIFO_DEPTH_LOG2(2)) u4 (
      .clk(clk), .reset(reset), .work_valid(v4), .work_ready(s4_ready),
      .work_midstate(work_midstate), .work_data(work_data),
      .work_nonce_start(ns), .work_nonce_end(ne), .work_abort(work_abort),
      .core_midstate(s4_mid), .core_data(s4_data), .core_nonce(s4_nonce),
      .core_issue(s4_issue), .core_lane_en(s4_en), .core_hash_valid(core_hash_valid),
      .core_hash_top(hash_top), .gold_valid(s4_gv), .gold_ready(gold_ready),
      .gold_nonce(s4_gn), .gold_drop(s4_drop), .busy(s4_busy), .done(s4_done));

   // Behavioural single-core model: only 195a2c52 hashes to h7 == 0 in the range.
   function automatic logic [31:0] core_model(input logic [31:0] n);
      return (n == 32'h195a2c52) ? 32'd0 : (n ^ 32'h5a5a_0001);
   endfunction

   task automatic do_reset();
      reset = 1'b1; v1 = 0; v2 = 0; v4 = 0; work_abort = 0; core_hash_valid = 0;
      gold_ready = 0; hash_top = '0; ns = '0; ne = '0;
      work_midstate = 256'h635ef71f_0c3d9a4e_5b6f21d0_8e7a4c13_2f9b6d55_a1c0e3f7_7d28b4a9_1620437b;
      work_data = 96'he5e1081ae9a4374e1e8d8d13;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++; if (s2_ready !== 1'b1 || s2_busy !== 1'b0 || s2_done !== 1'b0) begin
         $display("FAIL reset_state ready=%b busy=%b done=%b required 1 0 0", s2_ready, s2_busy, s2_done);
      end else pass_cnt++;
      total_cnt++; if (s2_issue !== 1'b0 || s2_en !== 2'b00 || s2_nonce !== 64'd0) begin
         $display("FAIL reset_core issue=%b en=%b nonce=%h required 0 00 0", s2_issue, s2_en, s2_nonce);
      end else pass_cnt++;
      total_cnt++; if (s2_mid !== 256'd0 || s2_data !== 96'd0) begin
         $display("FAIL reset_work mid=%h data=%h required 0", s2_mid, s2_data);
      end else pass_cnt++;
      total_cnt++; if (s2_gv !== 1'b0 || s2_gn !== 32'd0 || s2_drop !== 8'd0) begin
         $display("FAIL reset_fifo gv=%b gn=%h drop=%0d required 0 0 0", s2_gv, s2_gn, s2_drop);
      end else pass_cnt++;
      $display("test_reset done");
   endtask

   task automatic test_single_core();
      int done_cnt = 0;
      int done_at = -1;
      do_reset();
      ns = 32'h195a2c50; ne = 32'h195a2c54; v1 = 1'b1;
      @(negedge clk);
      v1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total_cnt++; if (s1_issue !== 1'b1 || s1_nonce !== ns + 32'(i) || s1_en !== 1'b1) begin
            $display("FAIL single_issue%0d issue=%b nonce=%h en=%b required 1 %h 1", i, s1_issue, s1_nonce, s1_en, ns + 32'(i));
         end else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++; if (s1_issue !== 1'b0 || s1_busy !== 1'b1 || s1_mid !== work_midstate || s1_data !== work_data) begin
         $display("FAIL single_drain issue=%b busy=%b mid=%h data=%h required 0 1 latched", s1_issue, s1_busy, s1_mid, s1_data);
      end else pass_cnt++;
      for (int g = 0; g < 5; g++) begin
         core_hash_valid = 1'b1; hash_top = {32'd0, core_model(ns + 32'(g))};
         @(negedge clk);
         if (s1_done) begin done_cnt++; done_at = g; end
      end
      core_hash_valid = 1'b0;
      repeat (3) begin @(negedge clk); if (s1_done) done_cnt++; end
      total_cnt++; if (done_cnt !== 1 || done_at !== 4) begin
         $display("FAIL single_done count=%0d at=%0d required 1 at 4", done_cnt, done_at);
      end else pass_cnt++;
      total_cnt++; if (s1_gv !== 1'b1 || s1_gn !== 32'h195a2c52 || s1_busy !== 1'b0) begin
         $display("FAIL single_gold gv=%b gn=%h busy=%b required 1 195a2c52 0", s1_gv, s1_gn, s1_busy);
      end else pass_cnt++;
      gold_ready = 1'b1; @(negedge clk); gold_ready = 1'b0;
      total_cnt++; if (s1_gv !== 1'b0 || s1_drop !== 8'd0) begin
         $display("FAIL single_one_gold gv=%b drop=%0d required 0 0", s1_gv, s1_drop);
      end else pass_cnt++;
      $display("test_single_core done");
   endtask

   task automatic test_lane_mask();
      logic [1:0] exp_en [3] = '{2'b11, 2'b11, 2'b01};
      logic [63:0] h [3] = '{64'h1111_1111_2222_2222, 64'h3333_3333_4444_4444, 64'h0000_0000_5555_5555};
      int done_at = -1;
      int extra = 0;
      do_reset();
      ns = 32'h10; ne = 32'h14; v2 = 1'b1;
      @(negedge clk);
      v2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total_cnt++; if (s2_issue !== 1'b1 || s2_nonce[31:0] !== 32'h10 + 32'(2*i) || s2_en !== exp_en[i]) begin
            $display("FAIL mask_issue%0d issue=%b lane0=%h en=%b required 1 %h %b", i, s2_issue, s2_nonce[31:0], s2_en, 32'h10 + 32'(2*i), exp_en[i]);
         end else pass_cnt++;
         @(negedge clk);
      end
      repeat (4) begin if (s2_issue) extra++; @(negedge clk); end
      total_cnt++; if (extra !== 0) begin
         $display("FAIL mask_extra_issue count=%0d required 0", extra);
      end else pass_cnt++;
      for (int g = 0; g < 3; g++) begin
         core_hash_valid = 1'b1; hash_top = h[g];
         @(negedge clk);
         if (s2_done) done_at = g;
      end
      core_hash_valid = 1'b0;
      total_cnt++; if (done_at !== 2 || s2_gv !== 1'b0 || s2_drop !== 8'd0) begin
         $display("FAIL mask_result done_at=%0d gv=%b drop=%0d required 2 0 0", done_at, s2_gv, s2_drop);
      end else pass_cnt++;
      $display("test_lane_mask done");
   endtask

   task automatic test_wrap();
      logic [63:0] exp_n [2] = '{64'hFFFFFFFF_FFFFFFFE, 64'h00000001_00000000};
      int done_at = -1;
      do_reset();
      ns = 32'hFFFFFFFE; ne = 32'h00000001; v2 = 1'b1;
      @(negedge clk);
      v2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         total_cnt++; if (s2_issue !== 1'b1 || s2_nonce !== exp_n[i] || s2_en !== 2'b11) begin
            $display("FAIL wrap_issue%0d issue=%b nonce=%h en=%b required 1 %h 11", i, s2_issue, s2_nonce, s2_en, exp_n[i]);
         end else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++; if (s2_issue !== 1'b0 || s2_busy !== 1'b1) begin
         $display("FAIL wrap_drain issue=%b busy=%b required 0 1", s2_issue, s2_busy);
      end else pass_cnt++;
      core_hash_valid = 1'b1; hash_top = 64'h1234_5678_9abc_def0;
      @(negedge clk); if (s2_done) done_at = 0;
      hash_top = 64'h0000_0000_0f0f_0f0f;
      @(negedge clk); if (s2_done) done_at = 1;
      core_hash_valid = 1'b0;
      total_cnt++; if (done_at !== 1 || s2_gv !== 1'b1 || s2_gn !== 32'h00000001) begin
         $display("FAIL wrap_result done_at=%0d gv=%b gn=%h required 1 1 00000001", done_at, s2_gv, s2_gn);
      end else pass_cnt++;
      $display("test_wrap done");
   endtask

   task automatic test_fifo_full();
      int done_at = -1;
      do_reset();
      ns = 32'd100; ne = 32'd111; v2 = 1'b1;
      @(negedge clk);
      v2 = 1'b0;
      repeat (6) @(negedge clk);
      for (int g = 0; g < 6; g++) begin
         core_hash_valid = 1'b1; hash_top = 64'd0;
         @(negedge clk);
         if (s2_done) done_at = g;
      end
      core_hash_valid = 1'b0;
      total_cnt++; if (s2_drop !== 8'd8 || done_at !== 5) begin
         $display("FAIL fifo_drop drop=%0d done_at=%0d required 8 5", s2_drop, done_at);
      end else pass_cnt++;
      gold_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total_cnt++; if (s2_gv !== 1'b1 || s2_gn !== 32'd100 + 32'(2*i)) begin
            $display("FAIL fifo_pop%0d gv=%b gn=%0d required 1 %0d", i, s2_gv, s2_gn, 100 + 2*i);
         end else pass_cnt++;
         @(negedge clk);
      end
      gold_ready = 1'b0;
      total_cnt++; if (s2_gv !== 1'b0) begin
         $display("FAIL fifo_empty gv=%b required 0", s2_gv);
      end else pass_cnt++;
      $display("test_fifo_full done");
   endtask

   task automatic test_abort();
      int done_cnt = 0;
      int gv_cnt = 0;
      do_reset();
      ns = 32'h1000; ne = 32'h1063; v2 = 1'b1;
      @(negedge clk);
      v2 = 1'b0;
      repeat (9) @(negedge clk);
      work_abort = 1'b1; core_hash_valid = 1'b1; hash_top = 64'd0;
      @(negedge clk);
      work_abort = 1'b0;
      total_cnt++; if (s2_busy !== 1'b0 || s2_ready !== 1'b1 || s2_issue !== 1'b0 || s2_en !== 2'b00) begin
         $display("FAIL abort_state busy=%b ready=%b issue=%b en=%b required 0 1 0 00", s2_busy, s2_ready, s2_issue, s2_en);
      end else pass_cnt++;
      repeat (5) begin @(negedge clk); if (s2_done) done_cnt++; if (s2_gv) gv_cnt++; end
      core_hash_valid = 1'b0;
      total_cnt++; if (done_cnt !== 0 || gv_cnt !== 0 || s2_drop !== 8'd0) begin
         $display("FAIL abort_ignore done=%0d gv=%0d drop=%0d required 0 0 0", done_cnt, gv_cnt, s2_drop);
      end else pass_cnt++;
      ns = 32'h2000; ne = 32'h2001; v2 = 1'b1;
      @(negedge clk);
      v2 = 1'b0;
      total_cnt++; if (s2_issue !== 1'b1 || s2_nonce !== 64'h00002001_00002000 || s2_en !== 2'b11) begin
         $display("FAIL abort_new_work issue=%b nonce=%h en=%b required 1 0000200100002000 11", s2_issue, s2_nonce, s2_en);
      end else pass_cnt++;
      core_hash_valid = 1'b1; hash_top = 64'h0000_0001_0000_0001;
      @(negedge clk);
      core_hash_valid = 1'b0;
      total_cnt++; if (s2_done !== 1'b1) begin
         $display("FAIL abort_new_done done=%b required 1", s2_done);
      end else pass_cnt++;
      $display("test_abort done");
   endtask

   task automatic test_loop_spacing();
      int last_c = -1;
      int n_iss = 0;
      int bad_gap = 0;
      int first_c = -1;
      do_reset();
      ns = 32'd0; ne = 32'd15; v4 = 1'b1;
      @(negedge clk);
      v4 = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (s4_issue) begin
            if (first_c < 0) first_c = c;
            if (last_c >= 0 && c - last_c != 4) bad_gap++;
            last_c = c; n_iss++;
         end
         @(negedge clk);
      end
      total_cnt++; if (first_c !== 1 || n_iss !== 8 || bad_gap !== 0) begin
         $display("FAIL loop_spacing first=%0d issues=%0d bad_gaps=%0d required 1 8 0", first_c, n_iss, bad_gap);
      end else pass_cnt++;
      core_hash_valid = 1'b1; hash_top = 64'h0000_0007_0000_0000;
      @(negedge clk);
      hash_top = 64'h0000_0003_0000_0004;
      @(negedge clk);
      core_hash_valid = 1'b0;
      total_cnt++; if (s4_busy !== 1'b1 || s4_gv !== 1'b1 || s4_gn !== 32'd0) begin
         $display("FAIL loop_predrain busy=%b gv=%b gn=%h required 1 1 0", s4_busy, s4_gv, s4_gn);
      end else pass_cnt++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total_cnt++; if (s4_busy !== 1'b0 || s4_ready !== 1'b1 || s4_issue !== 1'b0 || s4_en !== 2'b00 ||
                       s4_nonce !== 64'd0 || s4_mid !== 256'd0 || s4_data !== 96'd0 ||
                       s4_gv !== 1'b0 || s4_gn !== 32'd0 || s4_drop !== 8'd0 || s4_done !== 1'b0) begin
         $display("FAIL loop_reset busy=%b ready=%b issue=%b en=%b nonce=%h gv=%b drop=%0d required reset values",
                  s4_busy, s4_ready, s4_issue, s4_en, s4_nonce, s4_gv, s4_drop);
      end else pass_cnt++;
      $display("test_loop_spacing done");
   endtask

   initial begin
      test_reset();
      test_single_core();
      test_lane_mask();
      test_wrap();
      test_fifo_full();
      test_abort();
      test_loop_spacing();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/nonce_dispatch_collector.md
Name: nonce_dispatch_collector

Overview:
- Multi-core successor to the single-core nonce sequencing in fpgaminer_top.
- Accepts one work unit: midstate, data tail and a nonce range.
- Fans nonces out to NUM_CORES unrolled/looped double-SHA256 cores and tracks in-flight results without per-nonce storage.
- Queues golden nonces (final hash word h7 == 0) in a FIFO for the serial TX path.

Parameters:
- NUM_CORES, 2, hasher cores fed in parallel (1..8).
- LOOP_LOG2, 0, core loop factor; one issue every 2^LOOP_LOG2 cycles.
- FIFO_DEPTH_LOG2, 2, golden FIFO depth = 2^FIFO_DEPTH_LOG2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- work_valid  in  1  work unit offered
- work_ready  out  1  block accepts work (IDLE only)
- work_midstate  in  256  midstate
- work_data  in  96  last 12 bytes of header
- work_nonce_start  in  32  first nonce, inclusive
- work_nonce_end  in  32  last nonce, inclusive
- work_abort  in  1  abandon current work
- core_midstate  out  256  latched midstate to all cores
- core_data  out  96  latched data to all cores
- core_nonce  out  32*NUM_CORES  lane k nonce
- core_issue  out  1  cores sample inputs this cycle
- core_lane_en  out  NUM_CORES  lane carries an in-range nonce
- core_hash_valid  in  1  all cores present a result group this cycle
- core_hash_top  in  32*NUM_CORES  lane k final hash word h7
- gold_valid  out  1  FIFO non-empty
- gold_ready  in  1  consumer pops on valid&ready
- gold_nonce  out  32  FIFO head
- gold_drop  out  8  saturating count of lost golden nonces
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when range fully retired

Behaviour:
- Reset values: state IDLE; work_ready=1; core_issue=0; core_lane_en=0; core_nonce=0; core_midstate=0; core_data=0; FIFO empty; gold_valid=0; gold_nonce=0; gold_drop=0; busy=0; done=0.
- Range size: N = (end - start) mod 2^32 + 1, held as a 33-bit count. end < start wraps through 0xFFFFFFFF. start == end+1 (mod 2^32) gives N = 2^32.
- States:
  - IDLE: work_ready=1. On work_valid, latch all work fields. Load issue_nonce = start, res_nonce = start, issue_left = res_left = N. Next state RUN.
  - RUN: an issue timer counts 2^LOOP_LOG2 cycles; core_issue pulses when it expires, with the first pulse in the cycle after acceptance.
    - On each issue, lane k gets issue_nonce + k (mod 2^32), and core_lane_en[k] = (k < issue_left).
    - issue_nonce += NUM_CORES; issue_left -= min(NUM_CORES, issue_left).
    - When issue_left reaches 0, go to DRAIN.
  - DRAIN: no issues.
- Result retirement (RUN and DRAIN): on each core_hash_valid, lane k result nonce = res_nonce + k.
  - A lane counts only if k < res_left; out-of-range lanes are ignored.
  - res_nonce += NUM_CORES; res_left -= min(NUM_CORES, res_left).
  - When res_left reaches 0: done pulses one cycle, state returns to IDLE.
  - core_hash_valid while in IDLE is ignored.
- Golden detect: a counted lane with hash_top == 0 is golden.
  - One FIFO write per cycle; the lowest golden lane wins.
  - Any other golden lanes in the same cycle, and any write while the FIFO is full, increment gold_drop (saturating at 255).
  - A simultaneous pop and push on a full FIFO succeeds with no drop.
- FIFO is first-word-fall-through: gold_nonce is valid in the same cycle as gold_valid.
- work_abort (priority over everything except reset): state goes to IDLE in the next cycle, core_issue=0, core_lane_en=0, no done pulse. FIFO contents and gold_drop are kept. Results arriving after the abort are ignored.
- Reset mid-operation clears everything, including the FIFO.

Test Plan:
- Single-core known vector (NUM_CORES=1): midstate 635ef71f...1620437b, data e5e1081ae9a4374e1e8d8d13, range 195a2c50..195a2c54, behavioural core model. Required: exactly one gold_nonce=195a2c52; done pulses once after the 5th result.
- Lane masking (NUM_CORES=2): range 00000010..00000014. Required: 3 issues, last with core_lane_en=01; model returns h7=0 on the masked lane -> no FIFO write.
- Wrap range: start FFFFFFFE, end 00000001, NUM_CORES=2. Required: issued nonces FFFFFFFE, FFFFFFFF, 00000000, 00000001; done after 2 result groups.
- Simultaneous gold and full FIFO (depth 4, gold_ready=0): 2 result groups, each with both lanes golden, then 4 more golden groups. Required: FIFO holds the first 4 lowest-lane nonces; gold_drop=8.
- Abort in RUN: assert work_abort 10 cycles after acceptance, then hold core_hash_valid. Required: busy=0 next cycle, no done pulse, no FIFO writes; new work accepted afterwards.
- LOOP_LOG2=2: core_issue spacing is exactly 4 cycles; reset asserted mid-DRAIN -> all outputs return to reset values the next cycle.
